// File: rtl/addsub_seq.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// addsub_seq
//
// Digit-serial two's-complement adder/subtractor. Computes x + y or x - y
// over WIDTH bits, DIGIT bits per clock, least-significant digit first.
// Subtraction is done as x + ~y + 1: the y operand is inverted when it is
// captured and the carry chain is seeded with 1.
//
// A result takes N = WIDTH/DIGIT cycles from accept to out_valid. The
// result registers (s, c_out, ovf, zero) only change when an operation
// completes, so the consumer may read them at leisure.
//
// Parameters
//   WIDTH      operand/result width in bits (>= 2)
//   DIGIT      bits processed per clock (divides WIDTH)
//
// Ports
//   clk        clock, all logic on the rising edge
//   rst_n      synchronous active-low reset
//   in_valid   operands on x/y/sub are valid
//   in_ready   block can accept operands (only while idle)
//   x, y       operands
//   sub        0 = x + y, 1 = x - y
//   out_valid  result registers hold a new, unconsumed result
//   out_ready  consumer takes the result
//   s          sum/difference modulo 2^WIDTH
//   c_out      carry out of the MSB (for subtract: 1 = no borrow)
//   ovf        signed overflow
//   zero       s == 0
// ---------------------------------------------------------------------------
module addsub_seq #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             c_out,
    output logic             ovf,
    output logic             zero
);

    localparam int N     = (DIGIT > 0) ? (WIDTH / DIGIT) : 1;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] LAST_DIGIT = CNT_W'(N - 1);

    if (WIDTH < 2 || DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_param
        $error("addsub_seq: illegal WIDTH=%0d / DIGIT=%0d combination", WIDTH, DIGIT);
    end

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t state;
    state_t state_next;

    // Working registers. x_work and y_work shift right by one digit per RUN
    // cycle so the current digit is always in the low DIGIT bits; y_work is
    // already inverted for subtraction.
    logic [WIDTH-1:0] x_work;
    logic [WIDTH-1:0] y_work;
    logic [WIDTH-1:0] sum_work;
    logic             carry;
    logic [CNT_W-1:0] digit_cnt;

    logic [DIGIT-1:0] digit_x;
    logic [DIGIT-1:0] digit_y;
    logic [DIGIT-1:0] digit_sum;
    logic             digit_carry;
    logic [WIDTH-1:0] sum_next;
    logic             msb_carry_in;
    logic             last_digit;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and handshake decode. in_ready/out_valid depend only on
    // registered state, never on in_valid/out_ready.
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (last_digit) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // One digit of the addition. The new sum digit enters at the top of the
    // working sum, which shifts right, so after N digits the whole result is
    // in place. The carry into the operand MSB is recovered from that bit's
    // inputs and sum (a ^ b ^ cin = s), which avoids a DIGIT==1 special case.
    always_comb begin
        last_digit   = (digit_cnt == LAST_DIGIT);
        digit_x      = x_work[DIGIT-1:0];
        digit_y      = y_work[DIGIT-1:0];
        {digit_carry, digit_sum} = {1'b0, digit_x} + {1'b0, digit_y} + (DIGIT + 1)'(carry);
        sum_next     = WIDTH'({digit_sum, sum_work} >> DIGIT);
        msb_carry_in = digit_x[DIGIT-1] ^ digit_y[DIGIT-1] ^ digit_sum[DIGIT-1];
    end

    // Datapath: operand capture in IDLE, digit stepping in RUN, result load
    // on the final digit. Result registers are untouched otherwise.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            x_work    <= '0;
            y_work    <= '0;
            sum_work  <= '0;
            carry     <= 1'b0;
            digit_cnt <= '0;
            s         <= '0;
            c_out     <= 1'b0;
            ovf       <= 1'b0;
            zero      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        x_work    <= x;
                        y_work    <= y ^ {WIDTH{sub}};
                        sum_work  <= '0;
                        carry     <= sub;
                        digit_cnt <= '0;
                    end
                end
                RUN: begin
                    x_work    <= x_work >> DIGIT;
                    y_work    <= y_work >> DIGIT;
                    sum_work  <= sum_next;
                    carry     <= digit_carry;
                    digit_cnt <= digit_cnt + 1'b1;
                    if (last_digit) begin
                        s     <= sum_next;
                        c_out <= digit_carry;
                        ovf   <= msb_carry_in ^ digit_carry;
                        zero  <= (sum_next == '0);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_addsub_seq.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_addsub_seq
//
// Three instances of addsub_seq: DIGIT=4 (index 0), DIGIT=16 (index 1) and
// DIGIT=1 (index 2), all WIDTH=16. Stimulus pushes the expected result into
// a shared scoreboard queue; the monitor pops an entry whenever an
// instance's out_valid rises and checks value, flags, latency and which
// instance produced it.
// ---------------------------------------------------------------------------
module tb_addsub_seq;

    typedef struct {
        int          inst;
        logic [15:0] s;
        logic        c;
        logic        o;
        logic        z;
    } exp_t;

    localparam int LAT [3] = '{4, 1, 16};

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  in_valid = 3'b000;
    logic [2:0]  in_ready;
    logic [2:0]  out_valid;
    logic [15:0] x = 16'h0;
    logic [15:0] y = 16'h0;
    logic        sub = 1'b0;
    logic        out_ready = 1'b1;
    logic [15:0] s_v [3];
    logic [2:0]  c_v;
    logic [2:0]  o_v;
    logic [2:0]  z_v;

    exp_t sb[$];
    int   vec_count = 0;
    int   miscompares = 0;
    int   cyc = 0;
    int   acc_cyc [3];
    bit   seen [3];

    addsub_seq #(.WIDTH(16), .DIGIT(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .x(x), .y(y), .sub(sub), .out_valid(out_valid[0]), .out_ready(out_ready),
        .s(s_v[0]), .c_out(c_v[0]), .ovf(o_v[0]), .zero(z_v[0])
    );

    addsub_seq #(.WIDTH(16), .DIGIT(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .x(x), .y(y), .sub(sub), .out_valid(out_valid[1]), .out_ready(out_ready),
        .s(s_v[1]), .c_out(c_v[1]), .ovf(o_v[1]), .zero(z_v[1])
    );

    addsub_seq #(.WIDTH(16), .DIGIT(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .x(x), .y(y), .sub(sub), .out_valid(out_valid[2]), .out_ready(out_ready),
        .s(s_v[2]), .c_out(c_v[2]), .ovf(o_v[2]), .zero(z_v[2])
    );

    // Free-running clock and a cycle count used for latency measurement.
    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        vec_count++;
        if (act !== req) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    function automatic exp_t mk(input int inst, input logic [15:0] es,
                                input logic ec, input logic eo, input logic ez);
        exp_t e;
        e.inst = inst;
        e.s    = es;
        e.c    = ec;
        e.o    = eo;
        e.z    = ez;
        return e;
    endfunction

    // Reference model: 17-bit add of x and (possibly inverted) y plus sub;
    // overflow when both addends share a sign the result does not.
    function automatic exp_t model(input int inst, input logic [15:0] a,
                                   input logic [15:0] b, input logic sb_in);
        exp_t        e;
        logic [15:0] bb;
        logic [16:0] full;
        bb     = sb_in ? ~b : b;
        full   = {1'b0, a} + {1'b0, bb} + 17'(sb_in);
        e.inst = inst;
        e.s    = full[15:0];
        e.c    = full[16];
        e.o    = (a[15] == bb[15]) && (full[15] != a[15]);
        e.z    = (full[15:0] == 16'h0);
        return e;
    endfunction

    // Monitor: records the accept cycle, and on each rising out_valid pops
    // the next expectation and compares it with what the instance shows.
    always @(negedge clk) begin : monitor
        exp_t e;
        for (int i = 0; i < 3; i++) begin
            if (!rst_n) begin
                seen[i] = 1'b0;
            end else begin
                if (in_valid[i] && in_ready[i]) begin
                    acc_cyc[i] = cyc + 1;
                end
                if (out_valid[i] && !seen[i]) begin
                    seen[i] = 1'b1;
                    if (sb.size() == 0) begin
                        checkOutput($sformatf("spurious_result_inst%0d", i), 1, 0);
                    end else begin
                        e = sb.pop_front();
                        checkOutput($sformatf("result_inst%0d", i), i, e.inst);
                        checkOutput($sformatf("s_inst%0d", i), s_v[i], e.s);
                        checkOutput($sformatf("c_out_inst%0d", i), c_v[i], e.c);
                        checkOutput($sformatf("ovf_inst%0d", i), o_v[i], e.o);
                        checkOutput($sformatf("zero_inst%0d", i), z_v[i], e.z);
                        checkOutput($sformatf("latency_inst%0d", i), cyc - acc_cyc[i], LAT[i]);
                    end
                end
                if (out_valid[i] && out_ready) begin
                    seen[i] = 1'b0;
                end
            end
        end
    end

    // Queue the expectation, present operands and hold in_valid until the
    // instance accepts them.
    task automatic applyStimulus(input int inst, input logic [15:0] xa, input logic [15:0] ya,
                                 input logic sa, input exp_t e);
        int budget;
        sb.push_back(e);
        x = xa;
        y = ya;
        sub = sa;
        in_valid[inst] = 1'b1;
        budget = 0;
        do begin
            @(negedge clk);
            budget++;
        end while (!in_ready[inst] && budget < 50);
        if (!in_ready[inst]) begin
            checkOutput("accept_timeout", 0, 1);
        end
        @(posedge clk);
        #1;
        in_valid[inst] = 1'b0;
    endtask

    // Wait for the result to appear; complete the handshake if out_ready.
    task automatic waitResult(input int inst);
        int budget;
        budget = 0;
        do begin
            @(negedge clk);
            budget++;
        end while (!out_valid[inst] && budget < 40);
        if (!out_valid[inst]) begin
            checkOutput("result_timeout", 0, 1);
        end else if (out_ready) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin : watchdog
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : stimulus
        logic [15:0] xa;
        logic [15:0] ya;
        logic        sa;
        int          rel;
        int          budget;

        // Reset held for two edges with random inputs toggling.
        rst_n = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
            x        = 16'($urandom);
            y        = 16'($urandom);
            sub      = 1'($urandom);
            in_valid = 3'($urandom);
        end
        rst_n    = 1'b1;
        in_valid = 3'b000;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            checkOutput($sformatf("rst_in_ready%0d", i), in_ready[i], 1);
            checkOutput($sformatf("rst_out_valid%0d", i), out_valid[i], 0);
            checkOutput($sformatf("rst_s%0d", i), s_v[i], 0);
            checkOutput($sformatf("rst_c_out%0d", i), c_v[i], 0);
            checkOutput($sformatf("rst_ovf%0d", i), o_v[i], 0);
            checkOutput($sformatf("rst_zero%0d", i), z_v[i], 0);
        end
        @(posedge clk);
        #1;

        // Basic add and carry/overflow corners on the DIGIT=4 instance.
        applyStimulus(0, 16'h1234, 16'h0FFF, 1'b0, mk(0, 16'h2233, 1'b0, 1'b0, 1'b0));
        waitResult(0);
        applyStimulus(0, 16'h7FFF, 16'h0001, 1'b0, mk(0, 16'h8000, 1'b0, 1'b1, 1'b0));
        waitResult(0);
        applyStimulus(0, 16'hFFFF, 16'h0001, 1'b0, mk(0, 16'h0000, 1'b1, 1'b0, 1'b1));
        waitResult(0);
        applyStimulus(0, 16'h8000, 16'h0001, 1'b1, mk(0, 16'h7FFF, 1'b1, 1'b1, 1'b0));
        waitResult(0);
        applyStimulus(0, 16'h0005, 16'h0005, 1'b1, mk(0, 16'h0000, 1'b1, 1'b0, 1'b1));
        waitResult(0);
        applyStimulus(0, 16'h0003, 16'h0005, 1'b1, mk(0, 16'hFFFE, 1'b0, 1'b0, 1'b0));
        waitResult(0);

        // Backpressure: result held while a new operation is offered.
        out_ready = 1'b0;
        applyStimulus(0, 16'h00FF, 16'h0F01, 1'b0, mk(0, 16'h1000, 1'b0, 1'b0, 1'b0));
        waitResult(0);
        #1;
        sb.push_back(mk(0, 16'h9999, 1'b1, 1'b0, 1'b0));
        x = 16'hABCD;
        y = 16'h1234;
        sub = 1'b1;
        in_valid[0] = 1'b1;
        repeat (5) begin
            @(negedge clk);
            checkOutput("bp_out_valid", out_valid[0], 1);
            checkOutput("bp_in_ready", in_ready[0], 0);
            checkOutput("bp_s_stable", s_v[0], 16'h1000);
            checkOutput("bp_flags_stable", {c_v[0], o_v[0], z_v[0]}, 3'b000);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        rel = cyc;
        budget = 0;
        do begin
            @(negedge clk);
            budget++;
        end while (!in_ready[0] && budget < 10);
        @(posedge clk);
        #1;
        in_valid[0] = 1'b0;
        budget = 0;
        do begin
            @(negedge clk);
            budget++;
        end while (!out_valid[0] && budget < 20);
        checkOutput("bp_release_to_result", cyc - rel, 6);
        @(posedge clk);
        #1;

        // Reset in the middle of RUN discards the operation.
        applyStimulus(0, 16'h1111, 16'h2222, 1'b0, mk(0, 16'h3333, 1'b0, 1'b0, 1'b0));
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        sb.delete();
        @(negedge clk);
        checkOutput("midrst_in_ready", in_ready[0], 1);
        checkOutput("midrst_out_valid", out_valid[0], 0);
        checkOutput("midrst_s", s_v[0], 0);
        @(posedge clk);
        #1;
        applyStimulus(0, 16'h0001, 16'h0001, 1'b0, mk(0, 16'h0002, 1'b0, 1'b0, 1'b0));
        waitResult(0);

        // Random sweeps on the one-cycle and bit-serial instances.
        for (int inst = 1; inst < 3; inst++) begin
            for (int n = 0; n < 1000; n++) begin
                xa = 16'($urandom);
                ya = 16'($urandom);
                sa = 1'($urandom);
                if (n % 16 == 0) begin
                    ya = xa;
                end
                applyStimulus(inst, xa, ya, sa, model(inst, xa, ya, sa));
                waitResult(inst);
            end
        end

        repeat (5) @(negedge clk);
        checkOutput("scoreboard_drained", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
        $finish;
    end

endmodule
